// File: rtl/hd44780_pkg.sv
// hd44780_pkg: shared state encoding and command constants for the HD44780 4-bit sequencer
package hd44780_pkg;

    typedef enum logic [3:0] {
        RESET,
        POR_WAIT,
        INIT_NIB,
        INIT_WAIT,
        IDLE,
        SETUP_HI,
        E_HI_HI,
        GAP,
        SETUP_LO,
        E_HI_LO,
        POST_WAIT
    } state_t;

    localparam logic [3:0] INIT_NIB_3 = 4'h3;
    localparam logic [3:0] INIT_NIB_2 = 4'h2;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_HOME_ALT = 8'h03;

    // Clear and return-home need the long execution wait; everything else is short.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
        return !rs && (d == CMD_CLEAR || d == CMD_HOME || d == CMD_HOME_ALT);
    endfunction

endpackage

// File: rtl/hd44780_delay_timer.sv
// hd44780_delay_timer: loadable down-counter that flags the last cycle of a timed state
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load strobe, asserted on the edge that enters a timed state
//   load_val    cycle count for the state being entered (already clamped to >= 1)
//   expire      high on the cycle the count reaches 1, i.e. the state's last cycle
module hd44780_delay_timer #(
    parameter int W = 22
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= load ? load_val : (cnt == '0 ? cnt : cnt - 1'b1);
    end

    assign expire = cnt == W'(1);

endmodule

// File: rtl/hd44780_nibble_seq.sv
// hd44780_nibble_seq: writes bytes to an HD44780 LCD over the 4-bit bus with E pulse and execution-time pacing
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   stb, dat, rs        command request, byte, register select (0 instruction, 1 data)
//   ack                 one-cycle pulse when a request is accepted
//   busy                high while a write or the init sequence is running
//   init_done           high once the LCD accepts commands
//   lcd_rs, lcd_e       LCD RS and E pins
//   lcd_data            LCD DB7..DB4
// Build option: define HD44780_INIT_SEQ_EN to run the power-on 4-bit init nibbles after reset.
module hd44780_nibble_seq
    import hd44780_pkg::*;
#(
    parameter int E_HIGH_CYC     = 24,
    parameter int NIB_GAP_CYC    = 48,
    parameter int CMD_WAIT_CYC   = 2400,
    parameter int LONG_WAIT_CYC  = 96000,
    parameter int POR_WAIT_CYC   = 2400000,
    parameter int INIT_WAIT1_CYC = 197000,
    parameter int INIT_WAIT2_CYC = 4800,
    parameter int TIMER_BITS     = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stb,
    input  logic [7:0] dat,
    input  logic       rs,
    output logic       ack,
    output logic       busy,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_e,
    output logic [3:0] lcd_data
);

    localparam longint T_LIMIT = longint'(1) << TIMER_BITS;

    if (E_HIGH_CYC >= T_LIMIT || NIB_GAP_CYC >= T_LIMIT || CMD_WAIT_CYC >= T_LIMIT ||
        LONG_WAIT_CYC >= T_LIMIT || POR_WAIT_CYC >= T_LIMIT || INIT_WAIT1_CYC >= T_LIMIT ||
        INIT_WAIT2_CYC >= T_LIMIT) begin : g_timer_bits_check
        $error("hd44780_nibble_seq: TIMER_BITS too small for a *_CYC parameter");
    end

    // A zero count would never reach 1, so zero is clamped to a single cycle.
    localparam logic [TIMER_BITS-1:0] T_ONE  = TIMER_BITS'(1);
    localparam logic [TIMER_BITS-1:0] T_EH   = TIMER_BITS'(E_HIGH_CYC < 1 ? 1 : E_HIGH_CYC);
    localparam logic [TIMER_BITS-1:0] T_GAP  = TIMER_BITS'(NIB_GAP_CYC < 1 ? 1 : NIB_GAP_CYC);
    localparam logic [TIMER_BITS-1:0] T_CMD  = TIMER_BITS'(CMD_WAIT_CYC < 1 ? 1 : CMD_WAIT_CYC);
    localparam logic [TIMER_BITS-1:0] T_LONG = TIMER_BITS'(LONG_WAIT_CYC < 1 ? 1 : LONG_WAIT_CYC);
`ifdef HD44780_INIT_SEQ_EN
    localparam logic [TIMER_BITS-1:0] T_POR  = TIMER_BITS'(POR_WAIT_CYC < 1 ? 1 : POR_WAIT_CYC);
    localparam logic [TIMER_BITS-1:0] T_W1   = TIMER_BITS'(INIT_WAIT1_CYC < 1 ? 1 : INIT_WAIT1_CYC);
    localparam logic [TIMER_BITS-1:0] T_W2   = TIMER_BITS'(INIT_WAIT2_CYC < 1 ? 1 : INIT_WAIT2_CYC);
    logic [1:0] ini_idx;
`endif

    state_t                  state, next;
    logic                    accept, load, expire, long_q;
    logic [TIMER_BITS-1:0]   load_val;
    logic [7:0]              dat_q;

    assign accept = state == IDLE && init_done && stb;
    assign busy   = state != RESET && state != IDLE;
    // Every state change reloads the shared timer with the new state's duration.
    assign load   = next != state;

    always_comb begin
        next = state;
        case (state)
`ifdef HD44780_INIT_SEQ_EN
            RESET:     next = POR_WAIT;
            POR_WAIT:  next = expire ? INIT_NIB : state;
            INIT_NIB:  next = expire ? E_HI_HI : state;
            INIT_WAIT: next = expire ? (ini_idx == 2'd3 ? IDLE : INIT_NIB) : state;
`else
            RESET:     next = IDLE;
`endif
            IDLE:      next = accept ? SETUP_HI : state;
            SETUP_HI:  next = expire ? E_HI_HI : state;
            // The high-nibble E pulse is shared with the init nibbles, which skip the low half.
            E_HI_HI:   next = expire ? (init_done ? GAP : INIT_WAIT) : state;
            GAP:       next = expire ? SETUP_LO : state;
            SETUP_LO:  next = expire ? E_HI_LO : state;
            E_HI_LO:   next = expire ? POST_WAIT : state;
            POST_WAIT: next = expire ? IDLE : state;
            default:   next = RESET;
        endcase
    end

    always_comb begin
        load_val = T_ONE;
        case (next)
            E_HI_HI, E_HI_LO: load_val = T_EH;
            GAP:              load_val = T_GAP;
            POST_WAIT:        load_val = long_q ? T_LONG : T_CMD;
`ifdef HD44780_INIT_SEQ_EN
            POR_WAIT:         load_val = T_POR;
            INIT_WAIT:        load_val = ini_idx == 2'd0 ? T_W1 : ini_idx == 2'd1 ? T_W2 : T_CMD;
`endif
            default:          load_val = T_ONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RESET;
            ack       <= 1'b0;
            init_done <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_data  <= 4'h0;
            dat_q     <= 8'h00;
            long_q    <= 1'b0;
`ifdef HD44780_INIT_SEQ_EN
            ini_idx   <= 2'd0;
`endif
        end else begin
            state <= next;
            ack   <= accept;
            lcd_e <= next == E_HI_HI || next == E_HI_LO;
            if (next == IDLE)
                init_done <= 1'b1;
            // Bus values change only on setup entry, when E is guaranteed low.
            if (accept) begin
                dat_q    <= dat;
                long_q   <= is_long_cmd(rs, dat);
                lcd_rs   <= rs;
                lcd_data <= dat[7:4];
            end
            if (state == GAP && next == SETUP_LO)
                lcd_data <= dat_q[3:0];
`ifdef HD44780_INIT_SEQ_EN
            if (state == INIT_WAIT && next == INIT_NIB)
                ini_idx <= ini_idx + 2'd1;
            if (next == INIT_NIB && state != INIT_NIB) begin
                lcd_rs   <= 1'b0;
                lcd_data <= (state == INIT_WAIT && ini_idx == 2'd2) ? INIT_NIB_2 : INIT_NIB_3;
            end
`endif
        end
    end

    hd44780_delay_timer #(.W(TIMER_BITS)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

endmodule

// File: doc/hd44780_nibble_seq.md
Name: hd44780_nibble_seq

Overview:
- Sequencer driving the HD44780 LCD over the 4-bit bus (R/~W tied low, so write-only).
- Accepts one byte plus an RS flag through a strobe/ack handshake.
- Splits the byte into high and low nibbles, generates the E pulses, and holds off further commands for the controller's execution time.
- Sits between the top-level message/controller logic and the lcd_rs/lcd_e/lcd_data pins. The optional build adds the power-on 4-bit init sequence.

Parameters:
- E_HIGH_CYC, 24, E high time in clocks (500 ns @ 48 MHz).
- NIB_GAP_CYC, 48, E low time between the high and low nibbles (1 us).
- CMD_WAIT_CYC, 2400, post-command wait for ordinary commands and data (50 us).
- LONG_WAIT_CYC, 96000, post-command wait for clear/home (2 ms).
- POR_WAIT_CYC, 2400000, power-on wait before init (50 ms); used only with init.
- INIT_WAIT1_CYC, 197000, wait after the first init nibble (4.1 ms).
- INIT_WAIT2_CYC, 4800, wait after the second init nibble (100 us).
- TIMER_BITS, 22, delay counter width. Must hold every *_CYC value; an elaboration error fires if it does not.

Ports:
- CLK_I  in  1  system clock (48 MHz HFOSC)
- RST_N_I  in  1  asynchronous active-low reset
- STB_I  in  1  command request
- DAT_I  in  8  byte to write
- RS_I  in  1  0 = instruction, 1 = data
- ACK_O  out  1  one-cycle pulse: command accepted
- BUSY_O  out  1  high while a command or the init sequence is in progress
- INIT_DONE_O  out  1  high once the LCD is ready for commands
- lcd_rs  out  1  LCD RS pin
- lcd_e  out  1  LCD enable pin
- lcd_data  out  4  LCD DB7..DB4

Behaviour:
- Reset (async, RST_N_I=0): all outputs 0, state RESET, timer cleared. Asserting reset mid-pulse drops lcd_e immediately.
- States: RESET, POR_WAIT, INIT_NIB, INIT_WAIT, IDLE, SETUP_HI, E_HI_HI, GAP, SETUP_LO, E_HI_LO, POST_WAIT.
- Accept rule: only in IDLE with INIT_DONE_O=1. STB_I=1 at a clock edge (cycle 0) does the following:
  - latches DAT_I and RS_I;
  - sets ACK_O=1 for exactly cycle 1;
  - sets BUSY_O=1 from cycle 1 until the return to IDLE.
- STB_I in any other state is ignored: no ACK, nothing queued. The requester holds STB_I until it sees ACK_O.
- Write timing, in cycles after acceptance:
  - SETUP_HI, 1 cycle: lcd_rs=RS, lcd_data=DAT[7:4], lcd_e=0.
  - E_HI_HI, E_HIGH_CYC cycles: lcd_e=1.
  - GAP, NIB_GAP_CYC cycles: lcd_e=0, data held.
  - SETUP_LO, 1 cycle: lcd_data=DAT[3:0].
  - E_HI_LO, E_HIGH_CYC cycles: lcd_e=1.
  - POST_WAIT, W cycles: lcd_e=0.
  - Then IDLE with BUSY_O=0.
- Total busy time = 2 + 2*E_HIGH_CYC + NIB_GAP_CYC + W.
- W = LONG_WAIT_CYC when RS=0 and DAT in {0x01,0x02,0x03}; otherwise W = CMD_WAIT_CYC.
- lcd_rs and lcd_data never change while lcd_e=1. They hold their last values in IDLE.
- Delay counter:
  - Loaded with N at state entry; the state exits on the cycle the count reaches 1.
  - Decrement saturates at 0. A *_CYC value of 0 is treated as 1.
- The timer is shared by all states; one load per state entry.

Optional Feature:
- Macro: HD44780_INIT_SEQ_EN.
- Defined: after reset the sequence is:
  - RESET → POR_WAIT, POR_WAIT_CYC cycles;
  - then four init nibbles with RS=0, each sent as SETUP/E-high/E-low like a single nibble above:
    - 0x3, then wait INIT_WAIT1_CYC;
    - 0x3, then wait INIT_WAIT2_CYC;
    - 0x3, then wait CMD_WAIT_CYC;
    - 0x2, then wait CMD_WAIT_CYC;
  - then INIT_DONE_O=1 and IDLE.
- BUSY_O=1 throughout the sequence. Function-set and display commands are the requester's job.
- Undefined: RESET → IDLE on the first clock after reset release, INIT_DONE_O=1, BUSY_O=0. POR_WAIT_CYC, INIT_WAIT1_CYC and INIT_WAIT2_CYC are unused.

Decomposition:
- Package hd44780_pkg:
  - state enum;
  - init nibble constants (INIT_NIB_3=4'h3, INIT_NIB_2=4'h2);
  - long-command codes 0x01..0x03.
- Sub-module hd44780_delay_timer: load/count/expire counter of width TIMER_BITS. Inputs: load strobe and count. Output: expire pulse.

Test Plan:
All tests run with small parameters: E_HIGH_CYC=2, NIB_GAP_CYC=3, CMD_WAIT_CYC=5, LONG_WAIT_CYC=20, POR_WAIT_CYC=10, INIT_WAIT1_CYC=8, INIT_WAIT2_CYC=4.
- Data write, no init: STB_I with RS=1, DAT=0x48, held 1 cycle → ACK at cycle 1; lcd_data=0x4 during E pulse 1, 0x8 during E pulse 2; two E pulses, 2 cycles each; BUSY_O high exactly 14 cycles.
- Clear command: RS=0, DAT=0x01 → BUSY_O high 29 cycles. DAT=0x28 → 14 cycles.
- Busy rejection: STB_I held high through a write → single ACK; a second ACK arrives on the cycle after BUSY_O falls, for the held request.
- Init (HD44780_INIT_SEQ_EN): release reset → no E for 10 cycles; then E pulses carry nibbles 3,3,3,2 with gaps 8,4,5; INIT_DONE_O rises after the last wait; STB_I during init gets no ACK.
- Reset mid-pulse: assert RST_N_I while lcd_e=1 → lcd_e, BUSY_O and ACK_O go 0 without a clock edge; after release the block behaves as a fresh power-up.
- Stability: assertion that lcd_rs and lcd_data are constant whenever lcd_e=1, across 200 random commands.
